act_writeback: RTL and testbench

Downstream stage of the leaky ReLU activation unit. It absorbs the one-cycle `lr_valid_out`/`out` pulses, which cannot be stalled, into a small FIFO. It then writes them to the unified buffer over a valid/ready write port, using an auto-incrementing address. Each transfer is armed by a start command and ends with a `done` pulse once every expected value has been written.

---
 rtl/tpu_pkg.sv | 13 +
 rtl/act_writeback_fifo.sv | 69 ++++++
 rtl/act_writeback.sv | 123 ++++++++++++
 tb/tb_act_writeback.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: datapath width and the activation write-back FSM states.
package tpu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } wb_state_t;

endpackage

// File: rtl/act_writeback_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on head_data without a read strobe.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok, pop_ok;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/act_writeback.sv
// Buffers unstallable leaky-ReLU outputs and writes them to the unified buffer
// at auto-incrementing addresses, pulsing done once the armed count is written.
module act_writeback #(
  parameter int DATA_W = tpu_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic [ADDR_W-1:0]         cfg_base_addr,
  input  logic [ADDR_W-1:0]         cfg_count,
  input  logic                      act_valid_in,
  input  logic signed [DATA_W-1:0]  act_in,
  output logic                      ub_wr_en,
  output logic [ADDR_W-1:0]         ub_wr_addr,
  output logic [DATA_W-1:0]         ub_wr_data,
  input  logic                      ub_wr_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  import tpu_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  wb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] accept_cnt_q, accept_cnt_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              active, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (act_in),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign active     = (state_q == RUN) || (state_q == DRAIN);
  assign ub_wr_en   = active && !fifo_empty;
  assign ub_wr_addr = addr_q;
  assign ub_wr_data = fifo_head;
  assign busy       = active;
  assign done       = (state_q == DONE);
  assign overflow   = overflow_q;
  assign fifo_pop   = ub_wr_en && ub_wr_ready;
  assign fifo_push  = (state_q == RUN) && act_valid_in && (!fifo_full || fifo_pop);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    accept_cnt_d = accept_cnt_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    if (fifo_pop) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          count_d      = cfg_count;
          addr_d       = cfg_base_addr;
          accept_cnt_d = '0;
          overflow_d   = 1'b0;
          state_d      = (cfg_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Dropped samples still count, so a lossy burst cannot stall completion.
        if (act_valid_in) begin
          accept_cnt_d = accept_cnt_q + ADDR_W'(1);
          if (fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
          end
          if (accept_cnt_d == count_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty || (fifo_level == LVL_W'(1) && fifo_pop)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      accept_cnt_q <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      accept_cnt_q <= accept_cnt_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_act_writeback.sv
// Directed and randomized bench for act_writeback, checked every cycle against a
// queue-based transfer model plus fixed write logs for the directed scenarios.
module tb_act_writeback;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cfg_start;
  logic [ADDR_W-1:0]        cfg_base_addr;
  logic [ADDR_W-1:0]        cfg_count;
  logic                     act_valid_in;
  logic signed [DATA_W-1:0] act_in;
  logic                     ub_wr_en;
  logic [ADDR_W-1:0]        ub_wr_addr;
  logic [DATA_W-1:0]        ub_wr_data;
  logic                     ub_wr_ready;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   fifo_level;

  act_writeback #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_count     (cfg_count),
    .act_valid_in  (act_valid_in),
    .act_in        (act_in),
    .ub_wr_en      (ub_wr_en),
    .ub_wr_addr    (ub_wr_addr),
    .ub_wr_data    (ub_wr_data),
    .ub_wr_ready   (ub_wr_ready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: values waiting to be written, samples still expected, next address.
  logic [DATA_W-1:0]        m_q[$];
  bit                       m_busy;
  bit                       m_done;
  bit                       m_ovf;
  int                       m_remaining;
  logic [ADDR_W-1:0]        m_addr;
  logic [ADDR_W+DATA_W-1:0] dut_log[$];
  logic [ADDR_W+DATA_W-1:0] exp_log[$];
  logic [DATA_W-1:0]        sent[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    m_q.delete();
    m_busy      = 1'b0;
    m_done      = 1'b0;
    m_ovf       = 1'b0;
    m_remaining = 0;
    m_addr      = '0;
  endtask

  task automatic applyReset();
    rst           = 1'b1;
    cfg_start     = 1'b0;
    cfg_base_addr = '0;
    cfg_count     = '0;
    act_valid_in  = 1'b0;
    act_in        = '0;
    ub_wr_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelClear();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(ub_wr_en), 32'd0);
    checkOutput({tag, "_addr"},  32'(ub_wr_addr), 32'd0);
    checkOutput({tag, "_data"},  32'(ub_wr_data), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
    checkOutput({tag, "_done"},  32'(done), 32'd0);
    checkOutput({tag, "_ovf"},   32'(overflow), 32'd0);
    checkOutput({tag, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance both.
  task automatic applyStimulus(input bit start, input logic [ADDR_W-1:0] base,
                               input logic [ADDR_W-1:0] cnt, input bit valid,
                               input logic [DATA_W-1:0] d, input bit ready);
    bit exp_en, pop, was_full, draining, old_busy, old_done, n_done;
    cfg_start     = start;
    cfg_base_addr = base;
    cfg_count     = cnt;
    act_valid_in  = valid;
    act_in        = d;
    ub_wr_ready   = ready;
    exp_en = m_busy && (m_q.size() > 0);
    checkOutput("busy",     32'(busy), 32'(m_busy));
    checkOutput("done",     32'(done), 32'(m_done));
    checkOutput("wr_en",    32'(ub_wr_en), 32'(exp_en));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("level",    32'(fifo_level), 32'(m_q.size()));
    if (exp_en) begin
      checkOutput("wr_addr", 32'(ub_wr_addr), 32'(m_addr));
      checkOutput("wr_data", 32'(ub_wr_data), 32'(m_q[0]));
    end
    if (ub_wr_en && ub_wr_ready) dut_log.push_back({ub_wr_addr, ub_wr_data});

    old_busy = m_busy;
    old_done = m_done;
    pop      = exp_en && ready;
    was_full = (m_q.size() == DEPTH);
    draining = m_busy && (m_remaining == 0);
    n_done   = 1'b0;
    if (pop) begin
      void'(m_q.pop_front());
      m_addr++;
    end
    if (old_busy && m_remaining > 0 && valid) begin
      m_remaining--;
      if (!was_full || pop) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (draining && m_q.size() == 0) begin
      m_busy = 1'b0;
      n_done = 1'b1;
    end
    if (!old_busy && !old_done && start) begin
      m_addr = base;
      m_ovf  = 1'b0;
      if (cnt == 0) n_done = 1'b1;
      else begin
        m_busy      = 1'b1;
        m_remaining = int'(cnt);
      end
    end
    m_done = n_done;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input bit ready);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, ready);
  endtask

  task automatic checkLog(input string tag);
    logic [31:0] obs;
    checkOutput({tag, "_count"}, 32'(dut_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      obs = (i < dut_log.size()) ? 32'(dut_log[i]) : 'x;
      checkOutput($sformatf("%s_wr%0d", tag, i), obs, 32'(exp_log[i]));
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] rbase;
    logic [ADDR_W-1:0] rcnt;
    logic [DATA_W-1:0] v;
    int                cyc;

    applyReset();
    checkReset("reset");

    // Basic transfer with known values.
    $display("[TB] basic transfer");
    dut_log.delete();
    applyStimulus(1'b1, 8'h10, 8'd4, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'hFFFB, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0100, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0000, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h7FFF, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    checkOutput("basic_done", 32'(done), 32'd1);
    idleCycles(2, 1'b1);
    exp_log = '{24'h10FFFB, 24'h110100, 24'h120000, 24'h137FFF};
    checkLog("basic");

    // Backpressure: six samples held behind a stalled buffer.
    $display("[TB] backpressure");
    dut_log.delete();
    sent.delete();
    applyStimulus(1'b1, 8'h40, 8'd6, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom);
      sent.push_back(v);
      applyStimulus(1'b0, '0, '0, 1'b1, v, 1'b0);
    end
    checkOutput("bp_level_peak", 32'(fifo_level), 32'd6);
    idleCycles(3, 1'b0);
    checkOutput("bp_no_write", 32'(dut_log.size()), 32'd0);
    idleCycles(10, 1'b1);
    exp_log.delete();
    for (int i = 0; i < 6; i++) exp_log.push_back({8'(8'h40 + i), sent[i]});
    checkLog("bp");

    // Overflow: ten samples into eight entries with the buffer stalled.
    $display("[TB] overflow");
    dut_log.delete();
    sent.delete();
    applyStimulus(1'b1, 8'h80, 8'd10, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      v = 16'($urandom);
      sent.push_back(v);
      applyStimulus(1'b0, '0, '0, 1'b1, v, 1'b0);
    end
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_level", 32'(fifo_level), 32'd8);
    idleCycles(12, 1'b1);
    exp_log.delete();
    for (int i = 0; i < 8; i++) exp_log.push_back({8'(8'h80 + i), sent[i]});
    checkLog("ovf");

    // Zero-count start clears overflow and completes immediately.
    $display("[TB] zero count");
    dut_log.delete();
    applyStimulus(1'b1, 8'h55, 8'd0, 1'b0, '0, 1'b1);
    checkOutput("cnt0_done", 32'(done), 32'd1);
    checkOutput("cnt0_ovf_clear", 32'(overflow), 32'd0);
    idleCycles(2, 1'b1);
    checkOutput("cnt0_no_write", 32'(dut_log.size()), 32'd0);

    // Strobes while idle are ignored.
    $display("[TB] idle strobes");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 1'b1, 16'($urandom), 1'b1);
    checkOutput("idle_level", 32'(fifo_level), 32'd0);
    checkOutput("idle_no_write", 32'(dut_log.size()), 32'd0);

    // Address wrap, with a start issued mid-transfer that must be ignored.
    $display("[TB] wrap and busy start");
    dut_log.delete();
    applyStimulus(1'b1, 8'hFE, 8'd3, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h1111, 1'b1);
    applyStimulus(1'b1, 8'h33, 8'd9, 1'b1, 16'h2222, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h3333, 1'b1);
    idleCycles(4, 1'b1);
    exp_log = '{24'hFE1111, 24'hFF2222, 24'h003333};
    checkLog("wrap");

    // Reset part-way through a transfer, then a clean transfer.
    $display("[TB] reset mid-transfer");
    dut_log.delete();
    applyStimulus(1'b1, 8'h20, 8'd5, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'hAAAA, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h5555, 1'b0);
    applyReset();
    checkReset("midreset");
    idleCycles(3, 1'b1);
    applyStimulus(1'b1, 8'h30, 8'd3, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0001, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0002, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0003, 1'b1);
    idleCycles(4, 1'b1);
    exp_log = '{24'h300001, 24'h310002, 24'h320003};
    checkLog("after_reset");

    // Randomized transfers with random strobes and backpressure.
    $display("[TB] random transfers");
    for (int t = 0; t < 6; t++) begin
      rbase = 8'($urandom);
      rcnt  = 8'($urandom_range(1, 20));
      applyStimulus(1'b1, rbase, rcnt, 1'b0, '0, bit'($urandom_range(0, 1)));
      cyc = 0;
      while (m_busy && cyc < 300) begin
        applyStimulus(1'b0, '0, '0, (m_remaining > 0) && ($urandom_range(0, 9) < 7),
                      16'($urandom), $urandom_range(0, 9) < 6);
        cyc++;
      end
      vectors++;
      assert (!m_busy) else begin
        miscompares++;
        $error("[TB] FAIL random_timeout: observed %0d cycles expected completion", cyc);
      end
      idleCycles(2, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
